// File: rtl/ISO14443A_pkg.sv
// rtl/ISO14443A_pkg.sv - CRC_A constants, byte-wise CRC_A update and frame buffer FSM states
package ISO14443A_pkg;

  localparam logic [15:0] CRC_A_INIT = 16'h6363;
  localparam logic [15:0] CRC_A_POLY = 16'h8408;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DRAIN   = 2'd2
  } fb_state_t;

  // Reflected CRC_A over one byte, bit 0 (first bit on air) processed first.
  function automatic logic [15:0] crc_a_byte(logic [15:0] crc, logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = {1'b0, c[15:1]} ^ CRC_A_POLY;
      end else begin
        c = {1'b0, c[15:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_a.sv
// rtl/crc_a.sv - running CRC_A register with synchronous init and byte enable
module crc_a
  import ISO14443A_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc,
  output logic        residue_zero
);

  logic [15:0] crc_q;

  // Init wins over a byte update so a new frame always starts from CRC_A_INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC_A_INIT;
    end else if (init) begin
      crc_q <= CRC_A_INIT;
    end else if (en) begin
      crc_q <= crc_a_byte(crc_q, data);
    end
  end

  assign crc          = crc_q;
  assign residue_zero = (crc_q == 16'h0000);

endmodule

// File: rtl/rx_frame_buffer.sv
// rtl/rx_frame_buffer.sv - buffers one PCD frame, checks CRC_A, reports status and replays bytes
module rx_frame_buffer
  import ISO14443A_pkg::*;
#(
  parameter  int MAX_BYTES = 16,
  localparam int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          soc,
  input  logic          eoc,
  input  logic [7:0]    data,
  input  logic [2:0]    data_bits,
  input  logic          data_valid,
  input  logic          sequence_error,
  input  logic          parity_error,
  output logic          frame_done,
  output logic [LW-1:0] frame_bytes,
  output logic [2:0]    last_bits,
  output logic          crc_ok,
  output logic          overflow,
  output logic          rx_error,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy
);

  localparam int            IW      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [LW-1:0] MAX_CNT = LW'(MAX_BYTES);
  localparam logic [LW-1:0] MIN_CRC = LW'(3);

  fb_state_t     state_q;
  logic [LW-1:0] count_q, count_d;
  logic [LW-1:0] rd_q;
  logic [2:0]    lb_q, lb_d;
  logic          partial_q, partial_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [LW-1:0] frame_bytes_q;
  logic [2:0]    last_bits_q;
  logic          crc_ok_q, overflow_q, rx_error_q;
  logic          frame_done_q, out_valid_q;
  logic [7:0]    mem_q [MAX_BYTES];

  logic          take, fmt_err, store, drop, crc_en, crc_zero_d;
  logic [15:0]   crc_val;
  logic          residue_zero;

  crc_a u_crc_a (
    .clk          (clk),
    .rst          (rst),
    .init         (soc),
    .en           (crc_en && !soc),
    .data         (data),
    .crc          (crc_val),
    .residue_zero (residue_zero)
  );

  // Next-state of the frame accumulators, so a byte arriving with eoc is included in the status.
  always_comb begin
    take       = (state_q == ST_RECEIVE) && data_valid;
    fmt_err    = take && partial_q;
    store      = take && !partial_q && (count_q < MAX_CNT);
    drop       = take && !partial_q && (count_q >= MAX_CNT);
    crc_en     = take && !partial_q && (data_bits == 3'd0);
    count_d    = count_q + {{(LW-1){1'b0}}, store};
    lb_d       = store ? data_bits : lb_q;
    partial_d  = partial_q | (store && (data_bits != 3'd0));
    ovf_d      = ovf_q | drop;
    err_d      = err_q | fmt_err |
                 ((state_q == ST_RECEIVE) && (sequence_error || parity_error));
    crc_zero_d = crc_en ? (crc_a_byte(crc_val, data) == 16'h0000) : residue_zero;
  end

  // Frame buffer: stored elements land at the current count; a soc cycle writes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (store && !soc) begin
      mem_q[count_q[IW-1:0]] <= data;
    end
  end

  // Control FSM: soc restarts reception from any state; eoc latches status and starts the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      rd_q          <= '0;
      lb_q          <= 3'd0;
      partial_q     <= 1'b0;
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
      frame_bytes_q <= '0;
      last_bits_q   <= 3'd0;
      crc_ok_q      <= 1'b0;
      overflow_q    <= 1'b0;
      rx_error_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (soc) begin
        state_q       <= ST_RECEIVE;
        count_q       <= '0;
        rd_q          <= '0;
        lb_q          <= 3'd0;
        partial_q     <= 1'b0;
        ovf_q         <= 1'b0;
        err_q         <= 1'b0;
        frame_bytes_q <= '0;
        last_bits_q   <= 3'd0;
        crc_ok_q      <= 1'b0;
        overflow_q    <= 1'b0;
        rx_error_q    <= 1'b0;
        out_valid_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_RECEIVE: begin
            count_q   <= count_d;
            lb_q      <= lb_d;
            partial_q <= partial_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            if (eoc) begin
              frame_done_q  <= 1'b1;
              frame_bytes_q <= count_d;
              last_bits_q   <= lb_d;
              overflow_q    <= ovf_d;
              rx_error_q    <= err_d;
              crc_ok_q      <= crc_zero_d && (count_d >= MIN_CRC) &&
                               (lb_d == 3'd0) && !ovf_d;
              rd_q          <= '0;
              if (count_d != '0) begin
                state_q     <= ST_DRAIN;
                out_valid_q <= 1'b1;
              end else begin
                state_q     <= ST_IDLE;
              end
            end
          end
          ST_DRAIN: begin
            if (out_valid_q && out_ready) begin
              if (out_last) begin
                out_valid_q <= 1'b0;
                state_q     <= ST_IDLE;
              end else begin
                rd_q <= rd_q + LW'(1);
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_bytes = frame_bytes_q;
  assign last_bits   = last_bits_q;
  assign crc_ok      = crc_ok_q;
  assign overflow    = overflow_q;
  assign rx_error    = rx_error_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_valid_q ? mem_q[rd_q[IW-1:0]] : 8'h00;
  assign out_last    = out_valid_q && (rd_q == frame_bytes_q - LW'(1));
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb/tb_rx_frame_buffer.sv - randomized self-checking bench for rx_frame_buffer
module tb_rx_frame_buffer;

  localparam int MAXB = 16;
  localparam int LW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          soc = 1'b0;
  logic          eoc = 1'b0;
  logic [7:0]    data = 8'h00;
  logic [2:0]    data_bits = 3'd0;
  logic          data_valid = 1'b0;
  logic          sequence_error = 1'b0;
  logic          parity_error = 1'b0;
  logic          frame_done;
  logic [LW-1:0] frame_bytes;
  logic [2:0]    last_bits;
  logic          crc_ok, overflow, rx_error;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] f_data[$];
  logic [2:0] f_bits[$];
  logic [1:0] f_err[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  rx_frame_buffer #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .soc(soc), .eoc(eoc), .data(data), .data_bits(data_bits),
    .data_valid(data_valid), .sequence_error(sequence_error), .parity_error(parity_error),
    .frame_done(frame_done), .frame_bytes(frame_bytes), .last_bits(last_bits),
    .crc_ok(crc_ok), .overflow(overflow), .rx_error(rx_error), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic fb;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c  = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  function automatic logic [10:0] status_now();
    return {frame_bytes, last_bits, crc_ok, overflow, rx_error};
  endfunction

  function automatic bit same_stream();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_frame();
    f_data.delete(); f_bits.delete(); f_err.delete();
  endtask

  task automatic push_elem(input logic [7:0] d, input logic [2:0] b, input logic [1:0] e);
    f_data.push_back(d); f_bits.push_back(b); f_err.push_back(e);
  endtask

  // Frame-level reference: what a receiver holding MAXB bytes must report for the element list.
  task automatic model_frame(output logic [10:0] st);
    int cnt;
    bit partial, ovf, err;
    logic [2:0] lb;
    logic [15:0] c;
    cnt = 0; partial = 0; ovf = 0; err = 0; lb = 3'd0; c = 16'h6363;
    exp_q.delete();
    foreach (f_data[i]) begin
      if (f_err[i] != 2'b00) err = 1;
      if (partial) begin
        err = 1;
        continue;
      end
      if (f_bits[i] == 3'd0) c = ref_crc(c, f_data[i]);
      if (cnt < MAXB) begin
        exp_q.push_back(f_data[i]);
        cnt++;
        lb = f_bits[i];
        if (f_bits[i] != 3'd0) partial = 1;
      end else begin
        ovf = 1;
      end
    end
    st = {5'(cnt), lb, (c == 16'h0000) && (cnt >= 3) && (lb == 3'd0) && !ovf, ovf, err};
  endtask

  task automatic drive_frame(input bit do_soc, input bit eoc_same);
    if (do_soc) begin
      soc = 1'b1; tick(); soc = 1'b0;
    end
    for (int i = 0; i < f_data.size(); i++) begin
      repeat ($urandom_range(0, 2)) tick();
      data_valid = 1'b1; data = f_data[i]; data_bits = f_bits[i];
      parity_error = f_err[i][0]; sequence_error = f_err[i][1];
      if (eoc_same && i == f_data.size() - 1) eoc = 1'b1;
      tick();
      data_valid = 1'b0; parity_error = 1'b0; sequence_error = 1'b0;
      data = 8'($urandom); data_bits = 3'd0; eoc = 1'b0;
    end
    if (!(eoc_same && f_data.size() > 0)) begin
      repeat ($urandom_range(0, 2)) tick();
      eoc = 1'b1; tick(); eoc = 1'b0;
    end
  endtask

  task automatic collect(input bit rand_ready, output int last_idx, output int unstable, output bit timeout);
    bit hold, done;
    logic [7:0] prev;
    got_q.delete(); last_idx = -1; unstable = 0; timeout = 1; hold = 0; prev = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (hold && (!out_valid || out_data !== prev)) unstable++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      done = 0;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (out_last && last_idx < 0) last_idx = got_q.size() - 1;
        done = out_last;
      end
      hold = out_valid && !out_ready;
      prev = out_data;
      tick();
      if (done) begin
        timeout = 0;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({frame_done, frame_bytes, last_bits, crc_ok, overflow, rx_error, out_data, out_valid, out_last, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got fd=%0b fb=%0d lb=%0d ok=%0b ov=%0b err=%0b od=%h ov=%0b ol=%0b busy=%0b, want all 0",
               frame_done, frame_bytes, last_bits, crc_ok, overflow, rx_error, out_data, out_valid, out_last, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_frames();
    logic [10:0] want;
    int li, us;
    bit to;
    for (int k = 0; k < 4; k++) begin
      clear_frame();
      case (k)
        0: begin push_elem(8'h12,0,0); push_elem(8'h34,0,0); push_elem(8'h26,0,0); push_elem(8'hCF,0,0); want = {5'd4,3'd0,3'b100}; end
        1: begin push_elem(8'h00,0,0); push_elem(8'h00,0,0); push_elem(8'hA0,0,0); push_elem(8'h1F,0,0); want = {5'd4,3'd0,3'b000}; end
        2: begin push_elem(8'h00,0,0); push_elem(8'h00,0,0); push_elem(8'hA0,0,0); push_elem(8'h1E,0,0); want = {5'd4,3'd0,3'b100}; end
        default: begin push_elem(8'h26,3'd7,0); want = {5'd1,3'd7,3'b000}; end
      endcase
      exp_q = f_data;
      drive_frame(1'b1, 1'b0);
      n_checks++;
      if (frame_done !== 1'b1 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL known%0d_done: frame_done=%0b out_valid=%0b, want 1 1", k, frame_done, out_valid);
      end
      n_checks++;
      if (status_now() !== want) begin
        n_fail++;
        $display("FAIL known%0d_status: got %h, want %h", k, status_now(), want);
      end
      collect(1'b0, li, us, to);
      n_checks++;
      if (!same_stream() || li != exp_q.size() - 1 || to) begin
        n_fail++;
        $display("FAIL known%0d_stream: got %0d bytes last_idx=%0d timeout=%0b, want %0d bytes last_idx=%0d",
                 k, got_q.size(), li, to, exp_q.size(), exp_q.size() - 1);
      end
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL known%0d_idle: busy=%0b out_valid=%0b, want 0 0", k, busy, out_valid);
      end
    end
  endtask

  task automatic test_overflow();
    int li, us;
    bit to;
    clear_frame();
    for (int i = 0; i < MAXB + 2; i++) push_elem(8'($urandom), 3'd0, 2'b00);
    exp_q.delete();
    for (int i = 0; i < MAXB; i++) exp_q.push_back(f_data[i]);
    drive_frame(1'b1, 1'b0);
    n_checks++;
    if (status_now() !== {5'(MAXB), 3'd0, 3'b010}) begin
      n_fail++;
      $display("FAIL overflow_status: got %h, want %h", status_now(), {5'(MAXB), 3'd0, 3'b010});
    end
    collect(1'b1, li, us, to);
    n_checks++;
    if (!same_stream() || li != MAXB - 1 || us != 0 || to) begin
      n_fail++;
      $display("FAIL overflow_stream: got %0d bytes last_idx=%0d unstable=%0d timeout=%0b, want %0d bytes", got_q.size(), li, us, to, MAXB);
    end
  endtask

  task automatic test_parity_error();
    logic [15:0] c;
    int len, li, us;
    bit to;
    clear_frame();
    len = $urandom_range(3, 6);
    c = 16'h6363;
    for (int i = 0; i < len; i++) begin
      push_elem(8'($urandom), 3'd0, (i == 1) ? 2'b01 : 2'b00);
      c = ref_crc(c, f_data[i]);
    end
    push_elem(c[7:0], 3'd0, 2'b00);
    push_elem(c[15:8], 3'd0, 2'b00);
    exp_q = f_data;
    drive_frame(1'b1, 1'b1);
    n_checks++;
    if (status_now() !== {5'(len + 2), 3'd0, 3'b101}) begin
      n_fail++;
      $display("FAIL parity_status: got %h, want %h", status_now(), {5'(len + 2), 3'd0, 3'b101});
    end
    collect(1'b1, li, us, to);
    n_checks++;
    if (!same_stream() || li != len + 1 || us != 0 || to) begin
      n_fail++;
      $display("FAIL parity_stream: got %0d bytes last_idx=%0d unstable=%0d timeout=%0b, want %0d bytes", got_q.size(), li, us, to, len + 2);
    end
  endtask

  task automatic test_random_frames();
    logic [10:0] want;
    logic [15:0] c;
    int len, li, us;
    bit to;
    for (int it = 0; it < 25; it++) begin
      clear_frame();
      len = $urandom_range(0, MAXB + 2);
      for (int i = 0; i < len; i++)
        push_elem(8'($urandom), 3'd0, ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      if (len >= 1 && len <= MAXB - 2 && $urandom_range(0, 1) == 1) begin
        c = 16'h6363;
        foreach (f_data[i]) c = ref_crc(c, f_data[i]);
        push_elem(c[7:0], 3'd0, 2'b00);
        push_elem(c[15:8], 3'd0, 2'b00);
      end
      if ($urandom_range(0, 3) == 0) begin
        push_elem(8'($urandom), 3'($urandom_range(1, 7)), 2'b00);
        if ($urandom_range(0, 1) == 1) push_elem(8'($urandom), 3'd0, 2'b00);
      end
      model_frame(want);
      drive_frame(1'b1, 1'($urandom_range(0, 1)));
      n_checks++;
      if (frame_done !== 1'b1 || status_now() !== want) begin
        n_fail++;
        $display("FAIL random%0d_status: frame_done=%0b got %h, want 1 %h", it, frame_done, status_now(), want);
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL random%0d_empty: busy=%0b out_valid=%0b, want 0 0", it, busy, out_valid);
        end
      end else begin
        collect(1'b1, li, us, to);
        n_checks++;
        if (!same_stream() || li != exp_q.size() - 1 || us != 0 || to) begin
          n_fail++;
          $display("FAIL random%0d_stream: got %0d bytes last_idx=%0d unstable=%0d timeout=%0b, want %0d bytes",
                   it, got_q.size(), li, us, to, exp_q.size());
        end
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_soc_in_drain();
    int li, us;
    bit to;
    clear_frame();
    push_elem(8'h12,0,0); push_elem(8'h34,0,0); push_elem(8'h26,0,0); push_elem(8'hCF,0,0);
    out_ready = 1'b0;
    drive_frame(1'b1, 1'b0);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h12) begin
      n_fail++;
      $display("FAIL drain_hold: out_valid=%0b out_data=%h, want 1 12", out_valid, out_data);
    end
    soc = 1'b1; tick(); soc = 1'b0;
    n_checks++;
    if ({out_valid, frame_done, busy, frame_bytes} !== {3'b001, 5'd0}) begin
      n_fail++;
      $display("FAIL drain_abort: out_valid=%0b frame_done=%0b busy=%0b frame_bytes=%0d, want 0 0 1 0",
               out_valid, frame_done, busy, frame_bytes);
    end
    clear_frame();
    push_elem(8'h26, 3'd7, 2'b00);
    exp_q = f_data;
    drive_frame(1'b0, 1'b0);
    n_checks++;
    if (frame_done !== 1'b1 || status_now() !== {5'd1, 3'd7, 3'b000}) begin
      n_fail++;
      $display("FAIL drain_newframe: frame_done=%0b got %h, want 1 %h", frame_done, status_now(), {5'd1, 3'd7, 3'b000});
    end
    collect(1'b0, li, us, to);
    n_checks++;
    if (!same_stream() || li != 0 || to) begin
      n_fail++;
      $display("FAIL drain_newstream: got %0d bytes last_idx=%0d timeout=%0b, want 1 byte last_idx=0", got_q.size(), li, to);
    end
  endtask

  task automatic test_rst_mid_receive();
    bit seen;
    soc = 1'b1; tick(); soc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1; data = 8'($urandom); tick();
    end
    data_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({frame_done, frame_bytes, last_bits, crc_ok, overflow, rx_error, out_data, out_valid, out_last, busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_receive: fb=%0d busy=%0b out_valid=%0b fd=%0b, want all outputs 0", frame_bytes, busy, out_valid, frame_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    eoc = 1'b1; tick(); eoc = 1'b0;
    seen = frame_done | busy;
    tick();
    seen = seen | frame_done | busy;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_frame_done: frame_done/busy seen=%0b, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_known_frames();
    test_overflow();
    test_parity_error();
    test_random_frames();
    test_soc_in_drain();
    test_rst_mid_receive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
